// File: rtl/md5_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : md5_search_scheduler
// Purpose  : Issues candidate suffix indices to the MD5 datapath, tracks the
//            in-flight candidates in an in-order tag FIFO, checks returned
//            digests for leading zero nibbles and reports the lowest match.
// Options  : MD5_SEARCH_STATS_EN - enables the hashes_checked counter
//            (tied to zero when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module md5_search_scheduler #(
  parameter int INDEX_WIDTH  = 24,
  parameter int MAX_INFLIGHT = 8,
  parameter int START_INDEX  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [3:0]             zero_nibbles,
  output logic                   cand_valid,
  input  logic                   cand_ready,
  output logic [INDEX_WIDTH-1:0] cand_index,
  input  logic                   digest_valid,
  input  logic [127:0]           digest_data,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] result_index,
  output logic                   protocol_error,
  output logic [31:0]            hashes_checked
);

  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       c_max_inflight = CNT_W'(MAX_INFLIGHT);
  localparam logic [INDEX_WIDTH-1:0] c_start_index  = INDEX_WIDTH'(START_INDEX);
  localparam logic [INDEX_WIDTH-1:0] c_last_index   = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Reset is asserted asynchronously and released synchronously.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [3:0]             r_zn;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_cand_valid;
  logic                   w_cand_valid_next;
  logic                   r_exhausted;
  logic                   w_exhausted_next;
  logic [INDEX_WIDTH-1:0] r_fifo [MAX_INFLIGHT];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;
  logic                   r_found;
  logic [INDEX_WIDTH-1:0] r_result;
  logic                   r_perr;

  logic                   w_start_ok;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_match;
  logic                   w_first_match;
  logic [3:0]             w_zn_eff;
  logic [INDEX_WIDTH-1:0] w_head;

  // Only the top eight nibbles can ever be inspected.
  logic unused_digest_bits;
  assign unused_digest_bits = ^digest_data[95:0];

  // Two-flop release synchronizer for the internal reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_push        = r_cand_valid && cand_ready;
  assign w_pop         = digest_valid && (r_count != '0);
  assign w_head        = r_fifo[r_rd_ptr];
  assign w_zn_eff      = (r_zn > 4'd8) ? 4'd8 : r_zn;
  assign w_first_match = w_pop && w_match && (r_state == ST_ISSUE);
  assign w_exhausted_next = r_exhausted || (w_push && (r_index == c_last_index));

  // Leading-zero check over the first w_zn_eff nibbles of the digest.
  always_comb begin
    w_match = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < w_zn_eff) && (digest_data[127-4*i -: 4] != 4'd0)) begin
        w_match = 1'b0;
      end
    end
  end

  // Tag FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next state and next candidate-valid.
  always_comb begin
    w_next_state      = r_state;
    w_cand_valid_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_pop && w_match) begin
          // A handshake in the match cycle is already in w_count_next.
          w_next_state = (w_count_next == '0) ? ST_DONE : ST_DRAIN;
        end else if (r_exhausted && (w_count_next == '0)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (w_count_next == '0) w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_start_ok) begin
      w_cand_valid_next = 1'b1;
    end else if (w_next_state == ST_ISSUE) begin
      w_cand_valid_next = (w_count_next < c_max_inflight) && !w_exhausted_next;
    end
  end

  // Candidate index generator; stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_index      <= c_start_index;
      r_exhausted  <= 1'b0;
      r_cand_valid <= 1'b0;
      r_zn         <= 4'd0;
    end else begin
      r_cand_valid <= w_cand_valid_next;
      if (w_start_ok) begin
        r_index     <= c_start_index;
        r_exhausted <= 1'b0;
        r_zn        <= zero_nibbles;
      end else if (w_push) begin
        if (r_index == c_last_index) r_exhausted <= 1'b1;
        else                         r_index     <= r_index + 1'b1;
      end
    end
  end

  // Tag FIFO storage (no reset needed; validity is tracked by r_count).
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_index;
  end

  // Tag FIFO pointers and occupancy; flushed on an accepted start.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Result capture and the sticky protocol error.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_found  <= 1'b0;
      r_result <= '0;
      r_perr   <= 1'b0;
    end else begin
      if (digest_valid && (r_count == '0)) r_perr <= 1'b1;
      if (w_start_ok) begin
        r_found  <= 1'b0;
        r_result <= '0;
      end else if (w_first_match) begin
        r_found  <= 1'b1;
        r_result <= w_head;
      end
    end
  end

`ifdef MD5_SEARCH_STATS_EN
  logic [31:0] r_hashes;

  // Saturating count of digests evaluated since the last start.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hashes <= 32'd0;
    end else if (w_start_ok) begin
      r_hashes <= 32'd0;
    end else if (w_pop && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) &&
                 (r_hashes != 32'hFFFF_FFFF)) begin
      r_hashes <= r_hashes + 32'd1;
    end
  end
  assign hashes_checked = r_hashes;
`else
  assign hashes_checked = 32'd0;
`endif

  assign cand_valid     = r_cand_valid;
  assign cand_index     = r_cand_valid ? r_index : '0;
  assign busy           = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign done           = (r_state == ST_DONE);
  assign found          = r_found;
  assign result_index   = r_result;
  assign protocol_error = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_md5_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_search_scheduler
// Purpose  : Directed self-checking bench for md5_search_scheduler with a
//            fixed-latency in-order MD5 core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_search_scheduler;

  localparam int IW   = 4;
  localparam int MAXI = 8;
  // Planted digest: eight zero nibbles. Plain digest: exactly four.
  localparam logic [127:0] D_PLANT = 128'h00000000_F1111111_22222222_33333333;
  localparam logic [127:0] D_PLAIN = 128'h00001000_11111111_22222222_33333333;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    zero_nibbles = 4'd0;
  logic          cand_valid;
  logic          cand_ready = 1'b0;
  logic [IW-1:0] cand_index;
  logic          digest_valid = 1'b0;
  logic [127:0]  digest_data = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [IW-1:0] result_index;
  logic          protocol_error;
  logic [31:0]   hashes_checked;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat = 5;

  logic [IW-1:0] q_idx [$];
  int            q_due [$];

  int o_issued, o_presented, o_after_match, o_stall_viol, o_wrap0;
  int o_first_valid, o_done_cyc, o_last_pop;
  int o_first_idx, o_last_idx;
  bit o_timeout;

  md5_search_scheduler #(
    .INDEX_WIDTH (IW),
    .MAX_INFLIGHT(MAXI),
    .START_INDEX (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .zero_nibbles  (zero_nibbles),
    .cand_valid    (cand_valid),
    .cand_ready    (cand_ready),
    .cand_index    (cand_index),
    .digest_valid  (digest_valid),
    .digest_data   (digest_data),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .result_index  (result_index),
    .protocol_error(protocol_error),
    .hashes_checked(hashes_checked)
  );

  always #5 clk = ~clk;

  function automatic int exp_hashes(input int n);
`ifdef MD5_SEARCH_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    cand_ready = 1'b0;
    digest_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Starts a search and plays the MD5 core until done, budget or abort.
  task automatic run_search(input logic [3:0] zn, input logic [15:0] plant,
                            input int ready_pct, input int budget, input int abort_at);
    int cyc;
    logic [IW-1:0] idx;
    logic rdy, stalled, matched;
    logic [IW-1:0] stalled_idx;
    q_idx.delete();
    q_due.delete();
    o_issued = 0; o_presented = 0; o_after_match = 0; o_stall_viol = 0; o_wrap0 = 0;
    o_first_valid = -1; o_done_cyc = -1; o_last_pop = -1;
    o_first_idx = -1; o_last_idx = -1; o_timeout = 1'b0;
    start = 1'b1; zero_nibbles = zn; cand_ready = 1'b0; digest_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; stalled = 1'b0; matched = 1'b0; stalled_idx = '0;
    while (1'b1) begin
      if (done) begin o_done_cyc = cyc; break; end
      if (cyc >= budget) begin o_timeout = 1'b1; break; end
      if ((abort_at > 0) && (q_idx.size() >= abort_at)) break;
      if (cand_valid) begin
        if (o_first_valid < 0) o_first_valid = cyc;
        if (matched) o_after_match++;
        if (cand_index == '0) o_wrap0++;
        if (stalled && (cand_index != stalled_idx)) o_stall_viol++;
      end else if (stalled && !matched) begin
        o_stall_viol++;
      end
      rdy = ($urandom_range(99) < ready_pct);
      cand_ready = rdy;
      if (cand_valid && rdy) begin
        q_idx.push_back(cand_index);
        q_due.push_back(cyc + lat);
        o_issued++;
        if (o_first_idx < 0) o_first_idx = int'(cand_index);
        o_last_idx = int'(cand_index);
      end
      stalled = cand_valid && !rdy;
      stalled_idx = cand_index;
      if ((q_idx.size() > 0) && (q_due[0] <= cyc)) begin
        idx = q_idx.pop_front();
        void'(q_due.pop_front());
        digest_valid = 1'b1;
        digest_data = plant[idx] ? D_PLANT : D_PLAIN;
        o_presented++;
        o_last_pop = cyc;
        if (plant[idx] || (zn <= 4'd4)) matched = 1'b1;
      end else begin
        digest_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cand_ready = 1'b0;
    digest_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (cand_valid !== 1'b0) $display("FAIL reset_cand_valid: got %b expected 0", cand_valid); else pass_cnt++;
    total_cnt++; if (cand_index !== 4'd0) $display("FAIL reset_cand_index: got %0d expected 0", cand_index); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (found !== 1'b0) $display("FAIL reset_found: got %b expected 0", found); else pass_cnt++;
    total_cnt++; if (result_index !== 4'd0) $display("FAIL reset_result: got %0d expected 0", result_index); else pass_cnt++;
    total_cnt++; if (protocol_error !== 1'b0) $display("FAIL reset_perr: got %b expected 0", protocol_error); else pass_cnt++;
    total_cnt++; if (hashes_checked !== 32'd0) $display("FAIL reset_hashes: got %0d expected 0", hashes_checked); else pass_cnt++;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++; if ({busy, done, cand_valid} !== 3'b000) $display("FAIL reset_idle: got %b expected 000", {busy, done, cand_valid}); else pass_cnt++;
  endtask

  task automatic test_single_match();
    lat = 5;
    run_search(4'd5, 16'h0080, 100, 200, 0);
    total_cnt++; if (o_timeout !== 1'b0) $display("FAIL single_timeout: got %b expected 0", o_timeout); else pass_cnt++;
    total_cnt++; if ({done, found, busy} !== 3'b110) $display("FAIL single_flags: got %b expected 110", {done, found, busy}); else pass_cnt++;
    total_cnt++; if (result_index !== 4'd7) $display("FAIL single_result: got %0d expected 7", result_index); else pass_cnt++;
    total_cnt++; if (o_after_match != 0) $display("FAIL single_issue_after_match: got %0d expected 0", o_after_match); else pass_cnt++;
    total_cnt++; if (o_issued != 12) $display("FAIL single_issued: got %0d expected 12", o_issued); else pass_cnt++;
    total_cnt++; if ((q_idx.size() != 0) || (o_presented != 12)) $display("FAIL single_drained: got left=%0d returned=%0d expected 0/12", q_idx.size(), o_presented); else pass_cnt++;
    total_cnt++; if (o_done_cyc - o_last_pop != 1) $display("FAIL single_done_latency: got %0d expected 1", o_done_cyc - o_last_pop); else pass_cnt++;
    total_cnt++; if (hashes_checked !== 32'(exp_hashes(12))) $display("FAIL single_hashes: got %0d expected %0d", hashes_checked, exp_hashes(12)); else pass_cnt++;
  endtask

  task automatic test_random_ready();
    lat = 5;
    run_search(4'd5, 16'h1200, 50, 400, 0);
    total_cnt++; if (o_timeout !== 1'b0) $display("FAIL rand_timeout: got %b expected 0", o_timeout); else pass_cnt++;
    total_cnt++; if ({done, found} !== 2'b11) $display("FAIL rand_flags: got %b expected 11", {done, found}); else pass_cnt++;
    total_cnt++; if (result_index !== 4'd9) $display("FAIL rand_result: got %0d expected 9", result_index); else pass_cnt++;
    total_cnt++; if (o_stall_viol != 0) $display("FAIL rand_stall_stable: got %0d violations expected 0", o_stall_viol); else pass_cnt++;
    total_cnt++; if ((o_after_match != 0) || (q_idx.size() != 0)) $display("FAIL rand_drain: got after=%0d left=%0d expected 0/0", o_after_match, q_idx.size()); else pass_cnt++;
  endtask

  task automatic test_exhaust();
    lat = 5;
    run_search(4'd5, 16'h0000, 100, 200, 0);
    total_cnt++; if (o_timeout !== 1'b0) $display("FAIL exh_timeout: got %b expected 0", o_timeout); else pass_cnt++;
    total_cnt++; if ({done, found} !== 2'b10) $display("FAIL exh_flags: got %b expected 10", {done, found}); else pass_cnt++;
    total_cnt++; if (o_issued != 15) $display("FAIL exh_issued: got %0d expected 15", o_issued); else pass_cnt++;
    total_cnt++; if ((o_first_idx != 1) || (o_last_idx != 15)) $display("FAIL exh_range: got %0d..%0d expected 1..15", o_first_idx, o_last_idx); else pass_cnt++;
    total_cnt++; if (o_wrap0 != 0) $display("FAIL exh_wrap: got %0d zero indices expected 0", o_wrap0); else pass_cnt++;
    total_cnt++; if (q_idx.size() != 0) $display("FAIL exh_drained: got %0d left expected 0", q_idx.size()); else pass_cnt++;
    total_cnt++; if (hashes_checked !== 32'(exp_hashes(15))) $display("FAIL exh_hashes: got %0d expected %0d", hashes_checked, exp_hashes(15)); else pass_cnt++;
  endtask

  task automatic test_zero_nibbles();
    lat = 5;
    run_search(4'd0, 16'h0000, 100, 200, 0);
    total_cnt++; if (o_first_valid != 0) $display("FAIL zn0_start_latency: got %0d expected 0", o_first_valid); else pass_cnt++;
    total_cnt++; if ({done, found, result_index} !== {2'b11, 4'd1}) $display("FAIL zn0_result: got done/found=%b%b idx=%0d expected 11 idx=1", done, found, result_index); else pass_cnt++;
    run_search(4'd4, 16'h0000, 100, 200, 0);
    total_cnt++; if ({done, found, result_index} !== {2'b11, 4'd1}) $display("FAIL zn4_result: got done/found=%b%b idx=%0d expected 11 idx=1", done, found, result_index); else pass_cnt++;
    run_search(4'd9, 16'h0008, 100, 200, 0);
    total_cnt++; if ({done, found, result_index} !== {2'b11, 4'd3}) $display("FAIL zn9_clamp: got done/found=%b%b idx=%0d expected 11 idx=3", done, found, result_index); else pass_cnt++;
  endtask

  task automatic test_reset_mid_issue();
    lat = 10;
    run_search(4'd5, 16'h0000, 100, 100, 6);
    total_cnt++; if ((q_idx.size() != 6) || (busy !== 1'b1)) $display("FAIL mid_inflight: got %0d busy=%b expected 6 busy=1", q_idx.size(), busy); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if ({cand_valid, busy, done, found, protocol_error} !== 5'b0) $display("FAIL mid_reset_flags: got %b expected 00000", {cand_valid, busy, done, found, protocol_error}); else pass_cnt++;
    total_cnt++; if ({cand_index, result_index, hashes_checked} !== '0) $display("FAIL mid_reset_values: got %0d/%0d/%0d expected 0/0/0", cand_index, result_index, hashes_checked); else pass_cnt++;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    lat = 5;
    run_search(4'd0, 16'h0000, 100, 200, 0);
    total_cnt++; if (o_first_idx != 1) $display("FAIL mid_restart_index: got %0d expected 1", o_first_idx); else pass_cnt++;
    total_cnt++; if ({done, found, result_index, protocol_error} !== {2'b11, 4'd1, 1'b0}) $display("FAIL mid_restart_result: got %b%b idx=%0d perr=%b expected 11 idx=1 perr=0", done, found, result_index, protocol_error); else pass_cnt++;
  endtask

  task automatic test_protocol_error();
    do_reset();
    digest_valid = 1'b1;
    digest_data = D_PLANT;
    @(posedge clk); #1;
    digest_valid = 1'b0;
    total_cnt++; if (protocol_error !== 1'b1) $display("FAIL perr_set: got %b expected 1", protocol_error); else pass_cnt++;
    total_cnt++; if ({busy, done, found} !== 3'b000) $display("FAIL perr_state: got %b expected 000", {busy, done, found}); else pass_cnt++;
    lat = 5;
    run_search(4'd5, 16'h0008, 100, 200, 0);
    total_cnt++; if ({done, found, result_index} !== {2'b11, 4'd3}) $display("FAIL perr_search: got %b%b idx=%0d expected 11 idx=3", done, found, result_index); else pass_cnt++;
    total_cnt++; if (protocol_error !== 1'b1) $display("FAIL perr_sticky: got %b expected 1", protocol_error); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_random_ready();
    test_exhaust();
    test_zero_nibbles();
    test_reset_mid_issue();
    test_protocol_error();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
